// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared types and constants for the sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    // Default operand/result width of the divider
    localparam int DIV_WIDTH = 32;

    // Iteration counter must be able to hold the value WIDTH
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

    // Divider control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : en/complete request interface between the HI/LO unit
//                (master) and the sequential divider (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             en;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             complete;

    // Requester side
    modport master (
        output en, is_signed, dividend, divisor,
        input  quotient, remainder, complete
    );

    // Divider side
    modport slave (
        input  en, is_signed, dividend, divisor,
        output quotient, remainder, complete
    );
endinterface : seq_divider_if
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_div_step
//  Description : One radix-2 restoring division step (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic [WIDTH-1:0] partial_rem,
    input  wire logic             dividend_bit,
    input  wire logic [WIDTH-1:0] divisor_mag,
    output logic      [WIDTH-1:0] rem_out,
    output logic                  q_bit
);
    // One extra bit so the shifted remainder never overflows
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift in the next dividend bit, trial-subtract, restore on borrow.
    // With a nonzero divisor the remainder stays below the divisor, so the
    // MSB of the trial is a clean borrow flag. With a zero divisor both
    // branches produce the same low bits, so the remainder simply
    // accumulates the dividend.
    always_comb begin
        shifted = {partial_rem, dividend_bit};
        trial   = shifted - {1'b0, divisor_mag};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule : seq_divider_div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle radix-2 restoring signed/unsigned divider with
//                en/complete handshake. WIDTH iterations per divide; complete
//                pulses for one cycle with quotient/remainder valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic clk,
    input  wire logic reset,
    seq_divider_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] dividend_reg;   // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] partial_rem;
    logic             signed_reg;
    logic             sign_dividend;
    logic             sign_divisor;
    logic             div_zero;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;

    seq_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .partial_rem  (partial_rem),
        .dividend_bit (dividend_reg[WIDTH-1]),
        .divisor_mag  (divisor_mag),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Operand magnitudes at start, and sign-fixed results of the final step.
    // A zero divisor forces an all-ones quotient; its remainder path already
    // yields |dividend|, and the dividend-sign negation restores the original
    // bit pattern. The most-negative / -1 case wraps to itself naturally.
    always_comb begin
        dividend_abs = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        divisor_abs  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
        q_mag        = {dividend_reg[WIDTH-2:0], step_q};
        if (div_zero) begin
            q_fixed = '1;
        end else if (signed_reg && (sign_dividend != sign_divisor)) begin
            q_fixed = -q_mag;
        end else begin
            q_fixed = q_mag;
        end
        r_fixed = (signed_reg && sign_dividend) ? -step_rem : step_rem;
    end

    // Control FSM, iteration datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            counter       <= '0;
            dividend_reg  <= '0;
            divisor_mag   <= '0;
            partial_rem   <= '0;
            signed_reg    <= 1'b0;
            sign_dividend <= 1'b0;
            sign_divisor  <= 1'b0;
            div_zero      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.en) begin
                        dividend_reg  <= dividend_abs;
                        divisor_mag   <= divisor_abs;
                        signed_reg    <= bus.is_signed;
                        sign_dividend <= bus.dividend[WIDTH-1];
                        sign_divisor  <= bus.divisor[WIDTH-1];
                        div_zero      <= (bus.divisor == '0);
                        partial_rem   <= '0;
                        counter       <= '0;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!bus.en) begin
                        state <= ST_IDLE;
                    end else begin
                        partial_rem  <= step_rem;
                        dividend_reg <= q_mag;
                        counter      <= counter + CNT_W'(1);
                        if (counter == LAST_STEP) begin
                            quotient_reg  <= q_fixed;
                            remainder_reg <= r_fixed;
                            state         <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.complete  = (state == ST_DONE);

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Directed self-checking bench for seq_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   n;
    int   rises;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Count edges until complete rises (bounded)
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.complete && cnt < 40);
    endtask

    task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.en        = 1'b1;
    endtask

    // Full divide: latency, results, then release en and confirm the pulse ends
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int cnt;
        start(sgn, a, b);
        wait_done(cnt);
        check({tag, "_latency"}, 32'(cnt), 32'd33);
        check({tag, "_q"}, bus.quotient, eq);
        check({tag, "_r"}, bus.remainder, er);
        bus.en = 1'b0;
        tick();
        check({tag, "_pulse_end"}, {31'd0, bus.complete}, 32'd0);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.en        = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_q", bus.quotient, 32'd0);
        check("rst_r", bus.remainder, 32'd0);
        check("rst_complete", {31'd0, bus.complete}, 32'd0);

        // Unsigned 100/7 with en held through the following cycle
        start(1'b0, 32'd100, 32'd7);
        wait_done(n);
        check("u100_7_latency", 32'(n), 32'd33);
        check("u100_7_q", bus.quotient, 32'd14);
        check("u100_7_r", bus.remainder, 32'd2);
        tick();
        check("u100_7_cycle35", {31'd0, bus.complete}, 32'd0);
        bus.en = 1'b0;
        tick();

        // Signed cases
        run_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_div("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_div("u_max_7", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1);

        // Divide by zero
        run_div("s_div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("u_div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div("s_neg_div0", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321);

        // Abort at BUSY cycle 10
        start(1'b0, 32'd50, 32'd5);
        repeat (10) tick();
        bus.en = 1'b0;
        rises = 0;
        repeat (40) begin
            tick();
            if (bus.complete) rises++;
        end
        check("abort_no_complete", 32'(rises), 32'd0);
        check("abort_q_held", bus.quotient, 32'hFFFF_FFFF);
        check("abort_r_held", bus.remainder, 32'h8765_4321);

        // Reset at BUSY cycle 20
        start(1'b0, 32'd9, 32'd2);
        repeat (20) tick();
        reset = 1'b1;
        #1;
        check("midrst_q", bus.quotient, 32'd0);
        check("midrst_r", bus.remainder, 32'd0);
        check("midrst_complete", {31'd0, bus.complete}, 32'd0);
        bus.en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_div("u9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1);

        // Back-to-back with en held, operands switched after the first pulse;
        // mid-operation operand changes must be ignored
        start(1'b0, 32'd50, 32'd5);
        repeat (5) tick();
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'd3;
        bus.is_signed = 1'b1;
        wait_done(n);
        n += 5;
        check("b2b_first_latency", 32'(n), 32'd33);
        check("b2b_first_q", bus.quotient, 32'd10);
        check("b2b_first_r", bus.remainder, 32'd0);
        tick();
        check("b2b_gap", {31'd0, bus.complete}, 32'd0);
        start(1'b0, 32'd9, 32'd4);
        wait_done(n);
        check("b2b_spacing", 32'(n + 1), 32'd34);
        check("b2b_second_q", bus.quotient, 32'd2);
        check("b2b_second_r", bus.remainder, 32'd1);
        bus.en = 1'b0;
        tick();
        check("b2b_end", {31'd0, bus.complete}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring integer divider; the responder behind the EX-stage HI/LO unit's divide request (en/complete handshake).
- Accepts signed (DIV) or unsigned (DIVU) operands from the register read stage.
- Holds complete low while it iterates, so the pipeline stalls.
- Raises complete for exactly one cycle with quotient/remainder valid, which the HI/LO unit latches into LO/HI on that edge.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  divide request; held high by requester until complete seen; deassertion = abort
- is_signed  in  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU); sampled at start
- dividend  in  WIDTH  numerator (rs); sampled at start
- divisor  in  WIDTH  denominator (rt); sampled at start
- quotient  out  WIDTH  registered result; valid while complete=1
- remainder  out  WIDTH  registered result; valid while complete=1
- complete  out  1  decoded from state register; high only in DONE

Behaviour:
- Reset (any time, including mid-operation): state=IDLE, counter=0, quotient=0, remainder=0, complete=0.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - complete=0.
  - en=1 → latch |dividend|, |divisor| (magnitudes only when is_signed), the signs, is_signed, and a divisor==0 flag.
  - Clear partial remainder, counter=0, go to BUSY.
  - en=0 → stay in IDLE.
- BUSY:
  - Per cycle: shift {partial_rem, dividend_reg} left 1; trial = partial_rem − divisor_mag.
  - Trial non-negative → partial_rem=trial, quotient bit=1; else quotient bit=0.
  - counter++. After the WIDTH-th step, go to DONE.
  - On that same edge, write the sign-fixed results into quotient/remainder.
- DONE:
  - complete=1 for exactly one cycle, then unconditionally go to IDLE.
  - If en is still high in that IDLE cycle, a new operation starts with the operands then present. This gives back-to-back divides.
- Abort: en=0 in BUSY or DONE → IDLE on the next edge; quotient/remainder not updated by the aborted op.
- Latency: en first high in IDLE cycle N → complete=1 in cycle N+WIDTH+1 (N+33 for WIDTH=32).
- Sign fixup (signed only):
  - quotient negated iff sign(dividend)≠sign(divisor).
  - remainder negated iff dividend negative, so the remainder takes the dividend's sign.
  - Unsigned: no fixup.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. This falls out of the magnitude path; no special case.
- Divide by zero:
  - Still takes the full latency.
  - Quotient = all ones (0xFFFFFFFF); remainder = original dividend (unmodified bit pattern). Same result for both signed and unsigned.
- quotient/remainder hold their last value in IDLE/BUSY; they change only on the edge entering DONE.
- Operand inputs are ignored after start; changes during BUSY have no effect.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, BUSY=1, DONE=2)
  - DIV_WIDTH=32
  - counter width = clog2(WIDTH)+1
- One combinational sub-module, div_step: inputs partial_rem, next dividend bit, divisor_mag; outputs new partial_rem and quotient bit.
- Top level keeps the FSM, counter, operand/sign registers and the fixup logic.

Test Plan:
- Unsigned 100 / 7, en held high → complete low for 33 cycles, high in cycle 34 → quotient=14, remainder=2; complete low in cycle 35.
- Signed 0xFFFFFF9C (−100) / 7 → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2).
  - Signed 100 / 0xFFFFFFF9 (−7) → quotient −14, remainder 2.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 (signed and unsigned), dividend 0x12345678 → after full latency, quotient 0xFFFFFFFF, remainder 0x12345678.
- Abort and reset:
  - Drop en at BUSY cycle 10 → IDLE next edge, complete never rises, outputs keep the prior result.
  - Assert reset at BUSY cycle 20 → outputs 0 immediately, complete=0.
  - A later unsigned request 9/2 completes normally: quotient 4, remainder 1.
- Back-to-back: en held high across unsigned 50/5 then unsigned 9/4 (operands switched in the cycle after complete) → two complete pulses 34 cycles apart, with results (10,0) then (2,1).
